rect_fill_engine: RTL and testbench

Upstream command-driven drawing stage for the SDRAM framebuffer controller. It accepts one rectangle-fill command at a time (origin, size, RGB565 colour) and clips it to the visible area. It then issues one single-pixel write per pixel through the controller's call/done handshake, row by row, left to right. It replaces hard-coded fill sequencers with a reusable, clipped fill primitive.

---
 rtl/rect_fill_engine.sv | 182 ++++++++++++++++++
 tb/tb_rect_fill_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rect_fill_engine.sv
// Clipped rectangle-fill primitive: takes one fill command and issues one
// single-pixel write per visible pixel through the controller call/done handshake.
module rect_fill_engine #(
    parameter int X_W    = 9,
    parameter int Y_W    = 15,
    parameter int DATA_W = 16,
    parameter int H_RES  = 320,
    parameter int V_RES  = 240
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // Command handshake: a command transfers on a cycle where cmd_valid && cmd_ready.
    // cmd_ready is high only in IDLE; cmd_valid seen in any other state is dropped.
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [X_W-1:0]       cmd_x0,
    input  logic [Y_W-1:0]       cmd_y0,
    input  logic [X_W-1:0]       cmd_w,
    input  logic [Y_W-1:0]       cmd_h,
    input  logic [DATA_W-1:0]    cmd_color,
    output logic [1:0]           oCall,
    input  logic [1:0]           iDone,
    output logic [X_W+Y_W-1:0]   oAddr,
    output logic [DATA_W-1:0]    oData,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {IDLE, CLIP, WRITE, ADVANCE, FINISH} state_t;

    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

    state_t              state, state_nxt;
    logic [X_W-1:0]      x0_q, x0_nxt, w_q, w_nxt, x_end_q, x_end_nxt, cur_x_q, cur_x_nxt;
    logic [Y_W-1:0]      y0_q, y0_nxt, h_q, h_nxt, y_end_q, y_end_nxt, cur_y_q, cur_y_nxt;
    logic [DATA_W-1:0]   color_q, color_nxt;
    logic                call_wr_q, call_wr_nxt;
    logic [X_W+Y_W-1:0]  addr_q, addr_nxt;
    logic [DATA_W-1:0]   data_q, data_nxt;
    logic                busy_q, busy_nxt, done_q, done_nxt, err_q, err_nxt;

    // Sums carry one extra bit so a rectangle running past the edge cannot wrap.
    logic [X_W:0]        x_sum, x_lim;
    logic [Y_W:0]        y_sum, y_lim;
    logic                reject;
    logic                unused_rd_done;

    assign x_sum  = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum  = {1'b0, y0_q} + {1'b0, h_q};
    assign x_lim  = (x_sum > H_LIM) ? H_LIM : x_sum;
    assign y_lim  = (y_sum > V_LIM) ? V_LIM : y_sum;
    assign reject = ({1'b0, x0_q} >= H_LIM) || ({1'b0, y0_q} >= V_LIM) ||
                    (w_q == '0) || (h_q == '0);

    assign unused_rd_done = iDone[0];

    assign cmd_ready = (state == IDLE);
    assign oCall     = {call_wr_q, 1'b0};
    assign oAddr     = addr_q;
    assign oData     = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    always_comb begin
        state_nxt   = state;
        x0_nxt      = x0_q;
        y0_nxt      = y0_q;
        w_nxt       = w_q;
        h_nxt       = h_q;
        color_nxt   = color_q;
        x_end_nxt   = x_end_q;
        y_end_nxt   = y_end_q;
        cur_x_nxt   = cur_x_q;
        cur_y_nxt   = cur_y_q;
        call_wr_nxt = call_wr_q;
        addr_nxt    = addr_q;
        data_nxt    = data_q;
        busy_nxt    = busy_q;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    x0_nxt    = cmd_x0;
                    y0_nxt    = cmd_y0;
                    w_nxt     = cmd_w;
                    h_nxt     = cmd_h;
                    color_nxt = cmd_color;
                    busy_nxt  = 1'b1;
                    state_nxt = CLIP;
                end
            end
            CLIP: begin
                if (reject) begin
                    err_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    x_end_nxt   = X_W'(x_lim - 1'b1);
                    y_end_nxt   = Y_W'(y_lim - 1'b1);
                    cur_x_nxt   = x0_q;
                    cur_y_nxt   = y0_q;
                    call_wr_nxt = 1'b1;
                    addr_nxt    = {y0_q, x0_q};
                    data_nxt    = color_q;
                    state_nxt   = WRITE;
                end
            end
            WRITE: begin
                if (iDone[1]) begin
                    call_wr_nxt = 1'b0;
                    state_nxt   = ADVANCE;
                end
            end
            ADVANCE: begin
                if (cur_x_q == x_end_q && cur_y_q == y_end_q) begin
                    state_nxt = FINISH;
                end else begin
                    if (cur_x_q == x_end_q) begin
                        cur_x_nxt = x0_q;
                        cur_y_nxt = cur_y_q + Y_W'(1);
                    end else begin
                        cur_x_nxt = cur_x_q + X_W'(1);
                    end
                    call_wr_nxt = 1'b1;
                    addr_nxt    = {cur_y_nxt, cur_x_nxt};
                    data_nxt    = color_q;
                    state_nxt   = WRITE;
                end
            end
            FINISH: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            x0_q      <= '0;
            y0_q      <= '0;
            w_q       <= '0;
            h_q       <= '0;
            color_q   <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            call_wr_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            x0_q      <= x0_nxt;
            y0_q      <= y0_nxt;
            w_q       <= w_nxt;
            h_q       <= h_nxt;
            color_q   <= color_nxt;
            x_end_q   <= x_end_nxt;
            y_end_q   <= y_end_nxt;
            cur_x_q   <= cur_x_nxt;
            cur_y_q   <= cur_y_nxt;
            call_wr_q <= call_wr_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: a latency-programmable controller model answers
// write calls; every write is scored against a pixel list built from the fill rules.
module tb_rect_fill_engine;

    localparam int X_W    = 9;
    localparam int Y_W    = 15;
    localparam int DATA_W = 16;
    localparam int H_RES  = 320;
    localparam int V_RES  = 240;
    localparam int ENT_W  = X_W + Y_W + DATA_W;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [X_W-1:0]      cmd_x0 = '0;
    logic [Y_W-1:0]      cmd_y0 = '0;
    logic [X_W-1:0]      cmd_w = '0;
    logic [Y_W-1:0]      cmd_h = '0;
    logic [DATA_W-1:0]   cmd_color = '0;
    logic [1:0]          oCall;
    logic [1:0]          iDone;
    logic [X_W+Y_W-1:0]  oAddr;
    logic [DATA_W-1:0]   oData;
    logic                busy, done, err;

    logic                resp_done = 1'b0;
    logic                spur_done = 1'b0;
    logic                spur_rd   = 1'b0;
    assign iDone = {resp_done | spur_done, spur_rd};

    rect_fill_engine #(
        .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .H_RES(H_RES), .V_RES(V_RES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color),
        .oCall(oCall), .iDone(iDone), .oAddr(oAddr), .oData(oData),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [ENT_W-1:0] exp_q[$];
    bit  exp_reject;
    int  n_exp;
    int  wr0;
    int  lat = 3;
    int  wr_cnt = 0;
    int  pix_in_cmd = 0;
    int  overlap_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Controller model: answers each write call after lat+1 sampled cycles.
    int                 hold_cnt = 0;
    int                 low_run = 0;
    logic [X_W+Y_W-1:0] cap_addr;
    logic [DATA_W-1:0]  cap_data;
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (!rst_n) begin
            hold_cnt = 0;
            low_run  = 0;
        end else if (oCall[1]) begin
            if (hold_cnt == 0) begin
                wr_cnt++;
                if (pix_in_cmd > 0) check("gap_one_cycle", low_run, 1);
                pix_in_cmd++;
                cap_addr = oAddr;
                cap_data = oData;
                check("rd_call_zero", oCall[0], 0);
                check("col_in_range", oAddr[X_W-1:0] < H_RES, 1);
                check("row_in_range", oAddr[X_W+Y_W-1:X_W] < V_RES, 1);
                if (exp_q.size() == 0) check("unexpected_write", exp_q.size(), 1);
                else check("pixel", {oAddr, oData}, exp_q.pop_front());
            end else begin
                check("addr_stable", oAddr, cap_addr);
                check("data_stable", oData, cap_data);
            end
            low_run = 0;
            hold_cnt++;
            if (hold_cnt > lat) begin
                resp_done = 1'b1;
                hold_cnt  = 0;
            end
        end else begin
            low_run++;
        end
    end

    always @(negedge clk) begin
        if (done && err) overlap_cnt++;
        if (busy && cmd_ready) overlap_cnt++;
    end

    task automatic start_cmd(input int x0, input int y0, input int w, input int h,
                             input logic [DATA_W-1:0] color, input int l);
        int xe, ye, k;
        logic [X_W-1:0] cx;
        logic [Y_W-1:0] ry;
        exp_reject = (x0 >= H_RES) || (y0 >= V_RES) || (w == 0) || (h == 0);
        n_exp = 0;
        if (!exp_reject) begin
            xe = (x0 + w < H_RES) ? x0 + w - 1 : H_RES - 1;
            ye = (y0 + h < V_RES) ? y0 + h - 1 : V_RES - 1;
            for (int r = y0; r <= ye; r++) begin
                for (int c = x0; c <= xe; c++) begin
                    cx = X_W'(c);
                    ry = Y_W'(r);
                    exp_q.push_back({ry, cx, color});
                    n_exp++;
                end
            end
        end
        lat = l;
        for (k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
        check("ready_before_cmd", cmd_ready, 1);
        pix_in_cmd = 0;
        wr0        = wr_cnt;
        cmd_x0     = X_W'(x0);
        cmd_y0     = Y_W'(y0);
        cmd_w      = X_W'(w);
        cmd_h      = Y_W'(h);
        cmd_color  = color;
        cmd_valid  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", busy, 1);
        check("ready_low_after_accept", cmd_ready, 0);
    endtask

    task automatic finish_cmd(input bit inject);
        int k;
        int budget;
        bit ended;
        ended  = 1'b0;
        budget = n_exp * (lat + 3) + 20;
        for (k = 1; k <= budget; k++) begin
            if (inject && k == 5) begin
                cmd_x0    = 9'd1;
                cmd_y0    = 15'd100;
                cmd_w     = 9'd7;
                cmd_h     = 15'd9;
                cmd_color = 16'h1234;
                cmd_valid = 1'b1;
            end
            if (inject && k == 6) cmd_valid = 1'b0;
            @(negedge clk);
            if (done || err) begin
                ended = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
        if (!ended) begin
            check("timeout_waiting_done_or_err", k, budget + 1000);
        end else if (exp_reject) begin
            check("err_seen", err, 1);
            check("done_on_reject", done, 0);
            check("reject_latency", k, 1);
            check("reject_writes", wr_cnt - wr0, 0);
            check("ready_after_reject", cmd_ready, 1);
            check("busy_after_reject", busy, 0);
        end else begin
            check("done_seen", done, 1);
            check("err_on_fill", err, 0);
            check("busy_with_done", busy, 0);
            check("write_count", wr_cnt - wr0, n_exp);
            check("scoreboard_empty", exp_q.size(), 0);
        end
        @(negedge clk);
        check("pulse_one_cycle", {done, err}, 2'b00);
        check("ready_idle", cmd_ready, 1);
    endtask

    task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                           input logic [DATA_W-1:0] color, input int l, input bit inject);
        start_cmd(x0, y0, w, h, color, l);
        finish_cmd(inject);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_call"}, oCall, 0);
        check({tag, "_addr"}, oAddr, 0);
        check({tag, "_data"}, oData, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    initial begin
        int w0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(0, 0, 80, 2, 16'hF800, 3, 1'b0);
        run_cmd(300, 238, 50, 10, 16'h001F, 1, 1'b0);

        run_cmd(10, 10, 0, 4, 16'hAAAA, 2, 1'b0);
        run_cmd(10, 10, 4, 0, 16'hAAAA, 2, 1'b0);
        run_cmd(320, 10, 4, 4, 16'hAAAA, 2, 1'b0);
        run_cmd(10, 240, 4, 4, 16'hAAAA, 2, 1'b0);

        run_cmd(17, 33, 3, 2, 16'h5A5A, 20, 1'b0);

        run_cmd(319, 239, 1, 1, 16'h07E0, 2, 1'b0);
        w0 = wr_cnt;
        spur_done = 1'b1;
        spur_rd   = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        spur_rd   = 1'b0;
        repeat (3) @(negedge clk);
        check("spurious_writes", wr_cnt - w0, 0);
        check("spurious_busy", busy, 0);
        check("spurious_ready", cmd_ready, 1);

        run_cmd(40, 50, 6, 3, 16'hC0DE, 1, 1'b1);

        start_cmd(0, 0, 40, 4, 16'hBEEF, 2);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_abort");
        w0 = wr_cnt;
        repeat (3) @(negedge clk);
        check("abort_writes", wr_cnt - w0, 0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_cmd(5, 5, 2, 1, 16'h0F0F, 2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_cmd($urandom_range(0, 330), $urandom_range(0, 250),
                    $urandom_range(0, 12), $urandom_range(0, 6),
                    16'($urandom), $urandom_range(0, 4), 1'b0);
        end

        check("done_err_busy_ready_overlap", overlap_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
